// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with branch redirect; response lands in instr one cycle after imem_valid.
// Decode backpressure via instr_ready holds the fetched word; FETCH_PERF_EN adds a saturating stall_cnt output.
module fetch_unit #(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc_cur,
  output logic [PC_W-1:0]    pc_next,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_instr_valid;
  logic               w_instr_valid_nxt;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] w_instr_nxt;
  logic [PC_W-1:0]    r_instr_pc;
  logic [PC_W-1:0]    w_instr_pc_nxt;
  logic [PC_W-1:0]    r_drain_addr;
  logic [PC_W-1:0]    w_drain_addr_nxt;

  always_comb begin
    w_state_nxt       = r_state;
    w_instr_valid_nxt = r_instr_valid;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_drain_addr_nxt  = r_drain_addr;
    pc_next           = pc_cur;
    imem_req          = 1'b0;
    imem_addr         = pc_cur;

    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          // Response already here is simply dropped; otherwise it is still in flight and must be drained.
          if (imem_valid) begin
            w_state_nxt = REQ;
          end else begin
            w_drain_addr_nxt = pc_cur;
            w_state_nxt      = DRAIN;
          end
        end else if (imem_valid) begin
          w_instr_nxt       = imem_rdata;
          w_instr_pc_nxt    = pc_cur;
          w_instr_valid_nxt = 1'b1;
          pc_next           = pc_cur + PC_W'(1);
          w_state_nxt       = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = REQ;
        end
      end
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = r_drain_addr;
        // A redirect here only retargets the PC; the stale response still retires the drain.
        if (imem_valid) w_state_nxt = REQ;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (branch_taken) begin
      pc_next           = branch_target;
      w_instr_valid_nxt = 1'b0;
      if (r_state == IDLE || r_state == HOLD) w_state_nxt = REQ;
    end

    if (!reset) begin
      imem_req = 1'b0;
      pc_next  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_drain_addr  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_drain_addr  <= w_drain_addr_nxt;
    end
  end

  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

`ifdef FETCH_PERF_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ((r_state == REQ || r_state == DRAIN) && !imem_valid) ||
                   (r_state == HOLD && !instr_ready);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a transaction-level model of the fetch pipeline.
module tb_fetch_unit;
  localparam int PC_W    = 5;
  localparam int INSTR_W = 32;

  logic               clock;
  logic               reset;
  logic [PC_W-1:0]    pc_cur;
  logic [PC_W-1:0]    pc_next;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
`ifdef FETCH_PERF_EN
  logic [15:0]        stall_cnt;
`endif

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clock(clock),
    .reset(reset),
    .pc_cur(pc_cur),
    .pc_next(pc_next),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_valid(imem_valid),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .branch_taken(branch_taken),
    .branch_target(branch_target)
`ifdef FETCH_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Memory responder state
  logic               mem_busy = 1'b0;
  logic [PC_W-1:0]    mem_addr;
  int                 mem_cnt;
  logic [INSTR_W-1:0] mem_data;
  int                 lat_cfg = 0;
  logic               use_fixed = 1'b0;
  logic [INSTR_W-1:0] fixed_data = 32'h2002_0005;

  // Transaction-level model: is the unit waiting out a reset, holding a word, or owing a stale response?
  logic               m_idle = 1'b1;
  logic               m_held = 1'b0;
  logic               m_stale = 1'b0;
  logic [PC_W-1:0]    m_stale_addr = '0;
  logic [INSTR_W-1:0] m_instr = '0;
  logic [PC_W-1:0]    m_ipc = '0;
  logic [PC_W-1:0]    m_pc = '0;
  logic [15:0]        m_stall = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst_n, input logic br, input logic [PC_W-1:0] tgt, input logic rdy);
    logic               fire;
    logic               v;
    logic [INSTR_W-1:0] d;
    logic               e_req;
    logic [PC_W-1:0]    e_addr;
    logic               live;
    logic [PC_W-1:0]    e_pcn;
    @(posedge clock);
    #1;
    reset         = rst_n;
    branch_taken  = br;
    branch_target = tgt;
    instr_ready   = rdy;
    pc_cur        = m_pc;
    #1;
    fire = 1'b0;
    if (mem_busy) begin
      if (imem_req) chk("addr_stable", 32'(imem_addr), 32'(mem_addr));
      mem_cnt--;
      if (!imem_req || mem_cnt <= 0) fire = 1'b1;
    end else if (imem_req) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = (lat_cfg < 0) ? int'($urandom_range(3, 0)) : lat_cfg;
      mem_data = use_fixed ? fixed_data : $urandom;
      if (mem_cnt == 0) fire = 1'b1;
    end
    if (fire) begin
      imem_valid = 1'b1;
      imem_rdata = mem_data;
      mem_busy   = 1'b0;
    end else if (!imem_req && $urandom_range(3, 0) == 0) begin
      imem_valid = 1'b1;
      imem_rdata = $urandom;
    end else begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
    end
    #3;
    v      = imem_valid;
    d      = imem_rdata;
    e_req  = rst_n && !m_idle && !m_held;
    e_addr = m_stale ? m_stale_addr : m_pc;
    live   = e_req && !m_stale && v;
    if (!rst_n)    e_pcn = '0;
    else if (br)   e_pcn = tgt;
    else if (live) e_pcn = m_pc + PC_W'(1);
    else           e_pcn = m_pc;

    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", 32'(imem_addr), 32'(e_addr));
    chk("pc_next", 32'(pc_next), 32'(e_pcn));
    chk("instr_valid", 32'(instr_valid), 32'(m_held));
    chk("instr", instr, m_instr);
    chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
`ifdef FETCH_PERF_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif

    if (!rst_n) begin
      m_idle = 1'b1; m_held = 1'b0; m_stale = 1'b0; m_stale_addr = '0;
      m_instr = '0; m_ipc = '0; m_stall = '0;
    end else begin
      if (((e_req && !v) || (m_held && !rdy)) && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (br) begin
        if (e_req && !m_stale && !v) begin
          m_stale = 1'b1;
          m_stale_addr = m_pc;
        end else if (e_req && m_stale && v) begin
          m_stale = 1'b0;
        end
        m_held = 1'b0;
      end else begin
        if (m_held && rdy) m_held = 1'b0;
        if (e_req && m_stale && v) m_stale = 1'b0;
        if (live) begin
          m_held  = 1'b1;
          m_instr = d;
          m_ipc   = m_pc;
        end
      end
      m_idle = 1'b0;
    end
    m_pc = e_pcn;
  endtask

  initial begin
    reset = 1'b0; pc_cur = '0; imem_valid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // Reset, idle cycle, first request with a same-cycle memory response
    lat_cfg = 0; use_fixed = 1'b1;
    cycle(1'b0, 1'b0, '0, 1'b0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc_next", 32'(pc_next), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("cyc1_req", 32'(imem_req), 32'd0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    chk("cyc2_req", 32'(imem_req), 32'd1);
    chk("cyc2_addr", 32'(imem_addr), 32'd0);
    chk("cyc2_pc_next", 32'(pc_next), 32'd1);

    // Decode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      chk("hold_instr", instr, 32'h2002_0005);
      chk("hold_instr_pc", 32'(instr_pc), 32'd0);
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_pc_next", 32'(pc_next), 32'd1);
    end
    cycle(1'b1, 1'b0, '0, 1'b1);
    chk("consume_valid", 32'(instr_valid), 32'd1);
`ifdef FETCH_PERF_EN
    chk("stall_hold5", 32'(stall_cnt), 32'd5);
`endif

    // Redirect to 7 in HOLD together with instr_ready
    use_fixed = 1'b0;
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("fetch1_pc_next", 32'(pc_next), 32'd2);
    cycle(1'b1, 1'b1, 5'd7, 1'b1);
    chk("br7_pc_next", 32'(pc_next), 32'd7);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("br7_valid_drop", 32'(instr_valid), 32'd0);
    chk("br7_addr", 32'(imem_addr), 32'd7);

    // Redirect to 31 and fetch there to see the PC wrap
    cycle(1'b1, 1'b1, 5'd31, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("wrap_addr", 32'(imem_addr), 32'd31);
    chk("wrap_pc_next", 32'(pc_next), 32'd0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    chk("wrap_instr_pc", 32'(instr_pc), 32'd31);

    // Redirect to 12 while a 3-cycle fetch of address 0 is in flight
    lat_cfg = 3;
    cycle(1'b1, 1'b1, 5'd12, 1'b0);
    chk("br12_pc_next", 32'(pc_next), 32'd12);
    lat_cfg = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      chk("drain_req", 32'(imem_req), 32'd1);
      chk("drain_addr", 32'(imem_addr), 32'd0);
      chk("drain_pc_next", 32'(pc_next), 32'd12);
    end
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("post_drain_valid", 32'(instr_valid), 32'd0);
    chk("post_drain_addr", 32'(imem_addr), 32'd12);
    cycle(1'b1, 1'b0, '0, 1'b1);
    chk("post_drain_instr_pc", 32'(instr_pc), 32'd12);

    // Reset while a request is outstanding; its late response must be ignored
    lat_cfg = 3;
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    lat_cfg = 0;
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("after_rst_req", 32'(imem_req), 32'd0);
    chk("after_rst_valid", 32'(instr_valid), 32'd0);
    chk("after_rst_instr", instr, 32'd0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("after_rst_addr", 32'(imem_addr), 32'd0);

    // Random traffic
    lat_cfg = -1;
    for (int i = 0; i < 600; i++) begin
      cycle(logic'($urandom_range(60, 0) != 0), logic'($urandom_range(6, 0) == 0),
            PC_W'($urandom_range(31, 0)), logic'($urandom_range(2, 0) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 5: PC / instruction-address width.
REQ-002 Parameter INSTR_W, default 32: instruction word width.
REQ-003 The port list SHALL be, in this order (ports named name direction width meaning):
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clock edge.
- pc_cur  in  PC_W  current PC from the PC register.
- pc_next  out  PC_W  value the PC register loads next cycle.
- imem_req  out  1  instruction memory request.
- imem_addr  out  PC_W  request word address.
- imem_valid  in  1  response valid, one cycle per request.
- imem_rdata  in  INSTR_W  response data, qualified by imem_valid.
- instr_valid  out  1  instruction available to decode.
- instr  out  INSTR_W  fetched instruction.
- instr_pc  out  PC_W  address of instr.
- instr_ready  in  1  decode accepts instr.
- branch_taken  in  1  redirect pulse.
- branch_target  in  PC_W  redirect address.

Function
REQ-004 The FSM SHALL use the states IDLE, REQ, HOLD and DRAIN.
REQ-005 IDLE SHALL drive imem_req=0 and pc_next=pc_cur, and SHALL go to REQ next cycle.
REQ-006 REQ SHALL drive imem_req=1 and imem_addr=pc_cur; pc_next SHALL equal pc_cur until the response returns.
REQ-007 REQ with imem_valid=1 SHALL:
- register instr<=imem_rdata and instr_pc<=pc_cur;
- set instr_valid<=1;
- drive pc_next=pc_cur+1 modulo 2^PC_W (31 wraps to 0);
- go to HOLD.
REQ-008 HOLD SHALL drive imem_req=0, pc_next=pc_cur, and keep instr and instr_pc stable.
REQ-009 HOLD with instr_ready=1 SHALL clear instr_valid and go to REQ next cycle.
REQ-010 instr_ready SHALL be ignored when instr_valid=0.
REQ-011 imem_req and imem_addr SHALL stay stable from request until imem_valid; at most one request SHALL be outstanding.
REQ-012 branch_taken=1 SHALL have priority over all other events in every state: pc_next=branch_target that cycle, and instr_valid<=0.
REQ-013 Redirect in REQ with imem_valid=1 SHALL discard the response and go to REQ.
REQ-014 Redirect in REQ with imem_valid=0 SHALL latch drain_addr<=pc_cur and go to DRAIN.
REQ-015 DRAIN SHALL drive imem_req=1, imem_addr=drain_addr and pc_next=pc_cur, SHALL discard the response, and SHALL go to REQ when imem_valid=1.
REQ-016 Redirect while in DRAIN SHALL update pc_next only and remain in DRAIN.
REQ-017 Redirect in HOLD or IDLE SHALL drop any held instruction and go to REQ.
REQ-018 Redirect in HOLD simultaneous with instr_ready=1: the instruction SHALL count as consumed, and the redirect still applies.
REQ-019 imem_valid outside REQ/DRAIN SHALL be ignored.

Reset
REQ-020 reset=0 at a rising edge SHALL force state=IDLE and instr_valid=0, and set instr, instr_pc and drain_addr to 0.
REQ-021 During reset, imem_req SHALL be 0 and pc_next SHALL be 0.
REQ-022 Reset mid-operation SHALL abandon any outstanding request without waiting for imem_valid.
REQ-023 After reset release, the first request SHALL issue one cycle later, from IDLE.

Configuration
REQ-024 Macro FETCH_PERF_EN defined: add output stall_cnt[15:0], reset to 0.
- Increments each cycle in which state is REQ or DRAIN with imem_valid=0, or HOLD with instr_ready=0.
- Saturates at 16'hFFFF.
REQ-025 FETCH_PERF_EN undefined: the stall_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 Reset then release with pc_cur=0 and 1-cycle memory returning 32'h2002_0005 -> imem_req at cycle 2, instr_valid with instr=32'h2002_0005 and instr_pc=0, pc_next=1 in the capture cycle.
REQ-027 pc_cur=31, response valid -> pc_next=0 (wrap).
REQ-028 instr_ready held 0 for 5 cycles -> instr stable, imem_req=0, pc_next=pc_cur; with FETCH_PERF_EN, stall_cnt=5.
REQ-029 Redirect to 5'd12 in REQ while memory has 3-cycle latency -> state DRAIN, imem_addr holds old PC, stale response discarded, next request at address 12.
REQ-030 Redirect to 5'd7 in HOLD with instr_ready=1 same cycle -> instr_valid drops next cycle, pc_next=7, next request at address 7.
REQ-031 reset=0 asserted while a request is outstanding -> next cycle imem_req=0 and instr_valid=0; a late imem_valid is ignored.
